// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: derives BCLK/LRCLK from Clock and sends each held sample in both slots.
// Optional macro I2S_TX_HOLD_LAST_EN: on underrun repeat the last frame instead of sending silence.
module i2s_transmitter #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int CLK_DIV      = 8
) (
   input  logic                    Clock,
   input  logic                    nReset,
   input  logic [SAMPLE_WIDTH-1:0] sampleIn,
   input  logic                    sampleValid,
   output logic                    sampleReady,
   output logic                    bclk,
   output logic                    lrclk,
   output logic                    dacdat,
   output logic                    underrun
);

   localparam int                 DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]        r_div_count;
   logic                    r_bclk;
   logic [5:0]              r_bit_count;
   logic [SAMPLE_WIDTH-1:0] r_hold;
   logic                    r_hold_full;
   logic [SAMPLE_WIDTH-1:0] r_frame_reg;
   logic                    r_lrclk;
   logic                    r_dacdat;
   logic                    r_sample_ready;
   logic                    r_underrun;

   logic                    w_terminal;
   logic                    w_fall;
   logic [5:0]              w_bit_next;
   logic                    w_frame_start;
   logic                    w_accept;
   logic [4:0]              w_slot;
   logic [4:0]              w_tap;
   logic [31:0]             w_frame_ext;
   logic                    w_data_bit;
   logic [SAMPLE_WIDTH-1:0] w_fill;

   // Left-justifying the sample in a 32-bit slot makes slot s map to bit 32-s, with padding built in.
   always_comb begin
      w_terminal    = (r_div_count == DIV_LAST);
      w_fall        = w_terminal && r_bclk;
      w_bit_next    = r_bit_count + 6'd1;
      w_frame_start = w_fall && (w_bit_next == 6'd0);
      w_accept      = sampleValid && r_sample_ready;
      w_slot        = w_bit_next[4:0];
      w_tap         = 5'd0 - w_slot;
      w_frame_ext   = {r_frame_reg, {(32 - SAMPLE_WIDTH){1'b0}}};
      w_data_bit    = (w_slot != 5'd0) ? w_frame_ext[w_tap] : 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
      w_fill        = r_frame_reg;
`else
      w_fill        = '0;
`endif
   end

   // NOTE: every register here, including the sample-holding ones, is reset so that an abandoned
   // frame and any held sample are discarded; all updates are non-blocking to avoid ordering races.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_div_count    <= '0;
         r_bclk         <= 1'b0;
         r_bit_count    <= 6'd63;
         r_hold         <= '0;
         r_hold_full    <= 1'b0;
         r_frame_reg    <= '0;
         r_lrclk        <= 1'b0;
         r_dacdat       <= 1'b0;
         r_sample_ready <= 1'b1;
         r_underrun     <= 1'b0;
      end else begin
         r_underrun <= w_frame_start && !r_hold_full;

         if (w_terminal) begin
            r_div_count <= '0;
            r_bclk      <= !r_bclk;
         end else begin
            r_div_count <= r_div_count + DIV_W'(1);
         end

         if (w_fall) begin
            r_bit_count <= w_bit_next;
            r_lrclk     <= w_bit_next[5];
            r_dacdat    <= w_data_bit;
         end

         // A full holding register blocks the handshake, so consume and accept never collide.
         if (w_frame_start && r_hold_full) begin
            r_frame_reg    <= r_hold;
            r_hold_full    <= 1'b0;
            r_sample_ready <= 1'b1;
         end else begin
            if (w_frame_start) begin
               r_frame_reg <= w_fill;
            end
            if (w_accept) begin
               r_hold         <= sampleIn;
               r_hold_full    <= 1'b1;
               r_sample_ready <= 1'b0;
            end
         end
      end
   end

   assign sampleReady = r_sample_ready;
   assign bclk        = r_bclk;
   assign lrclk       = r_lrclk;
   assign dacdat      = r_dacdat;
   assign underrun    = r_underrun;

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serialises the 24-bit signed sample stream from the waveform generator into a Philips I2S bit stream for the board audio codec DAC. It generates the codec BCLK and LRCLK from the system clock and sends each accepted sample to both left and right slots (mono duplicated). A one-entry holding register, with a valid/ready handshake, decouples the sample producer from the frame timing.

## Interface
- SAMPLE_WIDTH, 24, sample bits per slot; 1..31.
- CLK_DIV, 8, Clock cycles per BCLK half-period; ≥2. BCLK period = 2·CLK_DIV; frame = 128·CLK_DIV Clock cycles.
- Clock  in  1  system clock; all state on rising edge.
- nReset  in  1  reset, asynchronous, active-low.
- sampleIn  in  SAMPLE_WIDTH  two's-complement sample.
- sampleValid  in  1  sampleIn valid.
- sampleReady  out  1  holding register empty; equals !holdFull, driven directly from a flop.
- bclk  out  1  codec bit clock.
- lrclk  out  1  0 = left slot, 1 = right slot.
- dacdat  out  1  serial data, MSB first.
- underrun  out  1  one-cycle pulse when a frame starts with no sample held.

## Operation
- Divider divCount counts 0..CLK_DIV-1. At terminal count it wraps and bclk toggles. A toggle 0→1 is a rise event; a toggle 1→0 is a fall event.
- bitCount (6 bits) advances on every fall event, wrapping 63→0. Reset value is 63, so the first fall event starts frame 0.
- Frame start is the fall event where bitCount becomes 0:
  - If holdFull: frameReg ← hold and holdFull ← 0.
  - Else: underrun pulses for one Clock, and frameReg gets the fill value (see Configuration).
- Handshake: when sampleValid && sampleReady: hold ← sampleIn and holdFull ← 1.
  - At frame start with holdFull=0, a simultaneous handshake writes hold only; underrun still pulses.
  - At frame start with holdFull=1, sampleReady is already 0, so no conflict.
- Outputs update on each fall event from the new bitCount b, with slot index s = b mod 32:
  - lrclk = b[5].
  - dacdat = frameReg[SAMPLE_WIDTH-s] for s in 1..SAMPLE_WIDTH; otherwise 0 (s=0 is the I2S one-bit delay; trailing bits are zero padding).
- The same frameReg feeds both slots.
- Reset values: bclk 0, lrclk 0, dacdat 0, sampleReady 1, underrun 0, divCount 0, bitCount 63, holdFull 0, hold 0, frameReg 0.

## Timing
- All outputs are registered. lrclk and dacdat change on the same Clock edge on which bclk falls, so they are stable across the codec's rising BCLK sample point.
- After reset release, the first bclk rise is at Clock edge CLK_DIV and the first fall (frame 0 start) is at edge 2·CLK_DIV.
- Latency from sample acceptance to its MSB on dacdat: the MSB appears 1 BCLK after the next frame start.
- sampleReady returns to 1 on the Clock cycle after frame start.
- At most one sample is consumed per frame. The producer must present a new sample every 128·CLK_DIV cycles to avoid underrun.
- Reset asserted mid-frame clears all state asynchronously. A partially sent frame is abandoned, and the held sample is discarded.

## Configuration
- I2S_TX_HOLD_LAST_EN defined: on underrun, frameReg keeps its previous value, so the last sample is repeated.
- Undefined: on underrun, frameReg ← 0 (silence).
- underrun pulses in both cases.

## Test plan
All scenarios use CLK_DIV=2, SAMPLE_WIDTH=24.
- Reset release, no input → bclk rises at edge 2 and falls at edge 4; lrclk, dacdat, underrun all 0; sampleReady=1; underrun pulses at edge 4.
- Present 24'hA5F00F before edge 4 → accepted in 1 cycle, sampleReady=0. Frame 0: dacdat slot bits 1..24 = A5F00F MSB first in both slots, all other bits 0. lrclk is low for 32 BCLKs, then high for 32.
- Hold sampleValid=1 with 24'h000001 then 24'h7FFFFF → second sample stalls with ready=0 until frame start, then is accepted on the following cycle. The LSB appears at slot bit 24 of the next frame.
- Send 24'h800000, then nothing → frame carries 1 followed by 23 zeros. The next frame pulses underrun and carries all zeros, or repeats 800000 with I2S_TX_HOLD_LAST_EN.
- Assert nReset at bitCount 40 with a sample held → all outputs return to reset values immediately, and sampleReady=1. After release, the next frame starts 2·CLK_DIV edges later with underrun.
- Handshake on the exact frame-start edge with holdFull=0 → underrun pulses, and the sample is output in the following frame.
